// File: rtl/stk_pipe_prev_ctrl.sv
// Linked-list controller for the 1024x12 prev-pointer SRAM: CTX_N LIFO stacks
// plus a shared LIFO free list, all threaded through one single-port SRAM.
module stk_pipe_prev_ctrl #(
  parameter int unsigned CTX_N = 4,
  parameter int unsigned N     = 1024,
  localparam int unsigned CW   = (CTX_N > 1) ? $clog2(CTX_N) : 1,
  localparam int unsigned PW   = 10
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_cmd_vld,
  input  logic             i_cmd_push,
  input  logic [CW-1:0]    i_cmd_ctx,
  output logic             o_cmd_rdy,
  output logic             o_rsp_vld,
  output logic [CW-1:0]    o_rsp_ctx,
  output logic [PW-1:0]    o_rsp_ptr,
  output logic             o_rsp_err,
  output logic [CTX_N-1:0] o_empty,
  output logic             o_full,
  output logic             o_busy_init,
  output logic [PW-1:0]    o_prev_addr,
  output logic [11:0]      o_prev_din,
  output logic             o_prev_ce,
  output logic             o_prev_oe,
  input  logic [11:0]      i_prev_dout
);

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_PUSH_RD,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_POP_WR
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q [CTX_N];
  logic [PW-1:0]     head_d [CTX_N];
  logic [CTX_N-1:0]  empty_q, empty_d;
  logic [PW-1:0]     free_head_q, free_head_d;
  logic [PW:0]       free_cnt_q, free_cnt_d;
  logic [PW-1:0]     init_cnt_q, init_cnt_d;
  logic [CW-1:0]     ctx_q, ctx_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [CW-1:0]     rsp_ctx_q, rsp_ctx_d;
  logic [PW-1:0]     rsp_ptr_q, rsp_ptr_d;
  logic              rsp_err_q, rsp_err_d;

  // Bit 11 of the SRAM word is reserved and never interpreted.
  logic              unused_dout_b11;
  assign unused_dout_b11 = i_prev_dout[11];

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    empty_d     = empty_q;
    free_head_d = free_head_q;
    free_cnt_d  = free_cnt_q;
    init_cnt_d  = init_cnt_q;
    ctx_d       = ctx_q;
    rsp_vld_d   = 1'b0;
    rsp_ctx_d   = rsp_ctx_q;
    rsp_ptr_d   = rsp_ptr_q;
    rsp_err_d   = rsp_err_q;
    o_cmd_rdy   = 1'b0;
    o_busy_init = 1'b0;
    o_prev_addr = '0;
    o_prev_din  = '0;
    o_prev_ce   = 1'b0;
    o_prev_oe   = 1'b0;

    case (state_q)
      ST_RST_WAIT: begin
        init_cnt_d = '0;
        state_d    = ST_INIT;
      end

      ST_INIT: begin
        // Chain entry i to i+1; the last entry wraps to 0 and carries null.
        o_busy_init = 1'b1;
        o_prev_ce   = 1'b1;
        o_prev_addr = init_cnt_q;
        o_prev_din  = {1'b0, (init_cnt_q == '1), init_cnt_q + 10'd1};
        init_cnt_d  = init_cnt_q + 10'd1;
        if (init_cnt_q == '1) begin
          free_head_d = '0;
          free_cnt_d  = 11'(N);
          state_d     = ST_IDLE;
        end
      end

      ST_IDLE: begin
        o_cmd_rdy = 1'b1;
        if (i_cmd_vld) begin
          ctx_d = i_cmd_ctx;
          if ((i_cmd_push && (free_cnt_q == '0)) ||
              (!i_cmd_push && empty_q[i_cmd_ctx])) begin
            rsp_vld_d = 1'b1;
            rsp_ctx_d = i_cmd_ctx;
            rsp_ptr_d = '0;
            rsp_err_d = 1'b1;
          end else if (i_cmd_push) begin
            state_d = ST_PUSH_RD;
          end else begin
            state_d = ST_POP_RD;
          end
        end
      end

      ST_PUSH_RD: begin
        o_prev_ce   = 1'b1;
        o_prev_oe   = 1'b1;
        o_prev_addr = free_head_q;
        state_d     = ST_PUSH_WR;
      end

      ST_PUSH_WR: begin
        o_prev_ce      = 1'b1;
        o_prev_addr    = free_head_q;
        o_prev_din     = {1'b0, empty_q[ctx_q], head_q[ctx_q]};
        head_d[ctx_q]  = free_head_q;
        empty_d[ctx_q] = 1'b0;
        free_head_d    = i_prev_dout[PW-1:0];
        free_cnt_d     = free_cnt_q - 11'd1;
        rsp_vld_d      = 1'b1;
        rsp_ctx_d      = ctx_q;
        rsp_ptr_d      = free_head_q;
        rsp_err_d      = 1'b0;
        state_d        = ST_IDLE;
      end

      ST_POP_RD: begin
        o_prev_ce   = 1'b1;
        o_prev_oe   = 1'b1;
        o_prev_addr = head_q[ctx_q];
        state_d     = ST_POP_WR;
      end

      ST_POP_WR: begin
        o_prev_ce      = 1'b1;
        o_prev_addr    = head_q[ctx_q];
        o_prev_din     = {1'b0, (free_cnt_q == '0), free_head_q};
        free_head_d    = head_q[ctx_q];
        free_cnt_d     = free_cnt_q + 11'd1;
        head_d[ctx_q]  = i_prev_dout[PW-1:0];
        empty_d[ctx_q] = i_prev_dout[PW];
        rsp_vld_d      = 1'b1;
        rsp_ctx_d      = ctx_q;
        rsp_ptr_d      = head_q[ctx_q];
        rsp_err_d      = 1'b0;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RST_WAIT;
      for (int unsigned i = 0; i < CTX_N; i++) head_q[i] <= '0;
      empty_q     <= '1;
      free_head_q <= '0;
      free_cnt_q  <= '0;
      init_cnt_q  <= '0;
      ctx_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_ctx_q   <= '0;
      rsp_ptr_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      empty_q     <= empty_d;
      free_head_q <= free_head_d;
      free_cnt_q  <= free_cnt_d;
      init_cnt_q  <= init_cnt_d;
      ctx_q       <= ctx_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_ctx_q   <= rsp_ctx_d;
      rsp_ptr_q   <= rsp_ptr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_ctx = rsp_ctx_q;
  assign o_rsp_ptr = rsp_ptr_q;
  assign o_rsp_err = rsp_err_q;
  assign o_empty   = empty_q;
  assign o_full    = (free_cnt_q == '0);

endmodule

// File: tb/tb_stk_pipe_prev_ctrl.sv
// Bench for stk_pipe_prev_ctrl: SRAM stub plus a queue-based model of the
// stacks and free list; directed scenarios followed by random commands.
module tb_stk_pipe_prev_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        i_cmd_vld = 1'b0;
  logic        i_cmd_push = 1'b0;
  logic [1:0]  i_cmd_ctx = '0;
  logic        o_cmd_rdy, o_rsp_vld, o_rsp_err, o_full, o_busy_init;
  logic [1:0]  o_rsp_ctx;
  logic [9:0]  o_rsp_ptr, o_prev_addr;
  logic [3:0]  o_empty;
  logic [11:0] o_prev_din, i_prev_dout;
  logic        o_prev_ce, o_prev_oe;

  stk_pipe_prev_ctrl #(.CTX_N(4), .N(1024)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_cmd_vld(i_cmd_vld), .i_cmd_push(i_cmd_push), .i_cmd_ctx(i_cmd_ctx),
    .o_cmd_rdy(o_cmd_rdy), .o_rsp_vld(o_rsp_vld), .o_rsp_ctx(o_rsp_ctx),
    .o_rsp_ptr(o_rsp_ptr), .o_rsp_err(o_rsp_err), .o_empty(o_empty),
    .o_full(o_full), .o_busy_init(o_busy_init), .o_prev_addr(o_prev_addr),
    .o_prev_din(o_prev_din), .o_prev_ce(o_prev_ce), .o_prev_oe(o_prev_oe),
    .i_prev_dout(i_prev_dout)
  );

  always #5 clk = ~clk;

  // Single-port SRAM stub with one-cycle read latency.
  logic [11:0] mem [1024];
  always @(posedge clk) begin
    if (o_prev_ce) begin
      if (o_prev_oe) i_prev_dout <= mem[o_prev_addr];
      else           mem[o_prev_addr] <= o_prev_din;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: each stack is a queue (top at back), free list is a LIFO (top at front).
  int unsigned stk [4][$];
  int unsigned fq [$];
  time         last_rsp_t;
  logic [9:0]  last_ptr;

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) stk[c].delete();
    fq.delete();
    for (int i = 0; i < 1024; i++) fq.push_back(i);
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int c = 0; c < 4; c++) e[c] = (stk[c].size() == 0);
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   o_cmd_rdy, 0);
    check({tag, "_rvld"},  o_rsp_vld, 0);
    check({tag, "_rptr"},  o_rsp_ptr, 0);
    check({tag, "_rerr"},  o_rsp_err, 0);
    check({tag, "_rctx"},  o_rsp_ctx, 0);
    check({tag, "_empty"}, o_empty, 4'hf);
    check({tag, "_full"},  o_full, 1);
    check({tag, "_ce"},    o_prev_ce, 0);
    check({tag, "_busy"},  o_busy_init, 0);
  endtask

  // Release reset (arst_n must be low on entry) and check the init sequence.
  task automatic run_init();
    int unsigned k = 0, nwr = 0, nbad = 0, nbusy = 0;
    logic [11:0] exp_din;
    @(negedge clk);
    arst_n = 1'b1;
    while (1) begin
      @(negedge clk);
      k++;
      if (o_busy_init) nbusy++;
      if (o_prev_ce && !o_prev_oe) begin
        exp_din = {1'b0, nwr == 1023, 10'((nwr + 1) % 1024)};
        if (o_prev_addr != 10'(nwr) || o_prev_din != exp_din) nbad++;
        nwr++;
      end
      if (o_cmd_rdy || k > 1100) break;
    end
    check("rdy_latency", k, 1025);
    check("init_writes", nwr, 1024);
    check("init_data_bad", nbad, 0);
    check("init_busy_cycles", nbusy, 1024);
    check("full_after_init", o_full, 0);
    check("empty_after_init", o_empty, 4'hf);
    model_reset();
  endtask

  // Issue one command at a negedge and check the response against the model.
  task automatic do_cmd(input bit push, input int unsigned ctx);
    int unsigned w = 0, lat = 1, nce = 0;
    bit          exp_err;
    int unsigned exp_ptr = 0;
    while (!o_cmd_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_cmd_rdy) begin
      check("rdy_timeout", 0, 1);
      return;
    end
    if (push) begin
      exp_err = (fq.size() == 0);
      if (!exp_err) begin
        exp_ptr = fq.pop_front();
        stk[ctx].push_back(exp_ptr);
      end
    end else begin
      exp_err = (stk[ctx].size() == 0);
      if (!exp_err) begin
        exp_ptr = stk[ctx].pop_back();
        fq.push_front(exp_ptr);
      end
    end
    i_cmd_vld  = 1'b1;
    i_cmd_push = push;
    i_cmd_ctx  = 2'(ctx);
    @(negedge clk);
    i_cmd_vld = 1'b0;
    while (1) begin
      if (o_prev_ce) nce++;
      if (o_rsp_vld || lat >= 8) break;
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, exp_err ? 1 : 3);
    check("sram_accesses", nce, exp_err ? 0 : 2);
    check("rsp_err", o_rsp_err, exp_err);
    check("rsp_ptr", o_rsp_ptr, exp_ptr);
    check("rsp_ctx", o_rsp_ctx, ctx);
    check("rdy_with_rsp", o_cmd_rdy, 1);
    check("empty", o_empty, model_empty());
    check("full", o_full, fq.size() == 0);
    last_rsp_t = $time;
    last_ptr   = o_rsp_ptr;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    run_init();

    // Push x3 then pop x3 on ctx0, back-to-back at 3-cycle spacing.
    do_cmd(1, 0); check("push0_a", last_ptr, 0); t0 = last_rsp_t;
    do_cmd(1, 0); check("push0_b", last_ptr, 1);
    check("push_spacing", 32'(last_rsp_t - t0), 30);
    do_cmd(1, 0); check("push0_c", last_ptr, 2);
    do_cmd(0, 0); check("pop0_a", last_ptr, 2);
    do_cmd(0, 0); check("pop0_b", last_ptr, 1);
    do_cmd(0, 0); check("pop0_c", last_ptr, 0);
    check("empty0_back", o_empty[0], 1);

    // Pop on empty stack: error response, no SRAM traffic.
    do_cmd(0, 1); check("pop_empty_err", o_rsp_err, 1);

    // Interleaved ops reuse freed entries LIFO.
    do_cmd(1, 0); check("il_push0", last_ptr, 0);
    do_cmd(1, 1); check("il_push1", last_ptr, 1);
    do_cmd(0, 0); check("il_pop0", last_ptr, 0);
    do_cmd(1, 2); check("il_push2", last_ptr, 0);
    check("il_empty", o_empty, 4'b1001);

    // Reset asserted during PUSH_WR.
    @(negedge clk);
    i_cmd_vld = 1'b1; i_cmd_push = 1'b1; i_cmd_ctx = 2'd0;
    @(negedge clk);
    i_cmd_vld = 1'b0;
    @(negedge clk);
    check("pushwr_ce", o_prev_ce, 1);
    check("pushwr_oe", o_prev_oe, 0);
    arst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    run_init();
    do_cmd(1, 0); check("reinit_push", last_ptr, 0);
    do_cmd(0, 0); check("reinit_pop", last_ptr, 0);

    // Exhaust the free list round-robin.
    for (int i = 0; i < 1024; i++) do_cmd(1, i % 4);
    check("full_after_1024", o_full, 1);
    do_cmd(1, 0); check("push_full_err", o_rsp_err, 1);
    do_cmd(0, 3); check("pop3_last", last_ptr, 1023);
    do_cmd(1, 1); check("push_after_free", last_ptr, 1023);

    // Random mix; drain half the entries first so both push and pop paths see traffic.
    for (int i = 0; i < 512; i++) do_cmd(0, i % 4);
    for (int i = 0; i < 600; i++) do_cmd(($urandom_range(0, 99) < 50), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stk_pipe_prev_ctrl.md
# stk_pipe_prev_ctrl

Linked-list controller that owns the 1024×12 `prev` pointer SRAM of the stack pipe memory and sits directly upstream of it. It maintains CTX_N independent LIFO stacks plus a shared free list, all threaded through the single-port `prev` SRAM. It accepts push and pop commands and returns the allocated or released entry index, which downstream stages use to address the stack data RAM.

## Interface

Parameters:
- CTX_N, 4, number of stacks (contexts); context id width is $clog2(CTX_N).
- N, 1024, number of entries; pointer width is 10. Fixed to match the SRAM depth.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset; one clock, asynchronous, active-low.
- i_cmd_vld  in  1  command valid.
- i_cmd_push  in  1  1 = push, 0 = pop.
- i_cmd_ctx  in  2  target stack.
- o_cmd_rdy  out  1  command accepted when vld&rdy.
- o_rsp_vld  out  1  single-cycle response pulse.
- o_rsp_ctx  out  2  context of the response.
- o_rsp_ptr  out  10  entry allocated (push) or released (pop); 0 on error.
- o_rsp_err  out  1  push while full, or pop while empty.
- o_empty  out  CTX_N  per-stack empty flags.
- o_full  out  1  free list exhausted.
- o_busy_init  out  1  free-list initialisation in progress.
- o_prev_addr  out  10  SRAM address.
- o_prev_din  out  12  SRAM write data, encoded as {1'b0, null, ptr[9:0]}.
- o_prev_ce  out  1  SRAM access enable.
- o_prev_oe  out  1  1 = read, 0 = write (valid only when ce=1).
- i_prev_dout  in  12  SRAM read data, valid the cycle after a read access.

## Operation

Registers:
- head[CTX_N] (10b), empty[CTX_N].
- free_head (10b), free_cnt (11b), init counter (10b).
- o_full = (free_cnt == 0).

State machine:
- RST_WAIT → INIT. RST_WAIT is the reset state and drives ce=0.
- INIT: each cycle writes prev[i] = {0, i==1023, (i+1)[9:0]}, then i++. After writing i=1023: free_head=0, free_cnt=1024, go to IDLE.
- IDLE: o_cmd_rdy=1. On accept:
  - Push while full, or pop while empty[ctx]: no SRAM access, o_rsp_err=1, stay in IDLE.
  - Push otherwise → PUSH_RD.
  - Pop otherwise → POP_RD.
- PUSH_RD: read prev[free_head].
- PUSH_WR:
  - nxt = dout[9:0].
  - Write prev[free_head] = {0, empty[ctx], head[ctx]}.
  - head[ctx] = free_head; empty[ctx] = 0; free_head = nxt; free_cnt--.
  - Response ptr = old free_head. Go to IDLE.
- POP_RD: read prev[head[ctx]].
- POP_WR:
  - Write prev[head[ctx]] = {0, free_cnt==0, free_head}.
  - free_head = head[ctx]; free_cnt++.
  - head[ctx] = dout[9:0]; empty[ctx] = dout[10].
  - Response ptr = old head. Go to IDLE.
- Command ctx and op are latched at accept. Inputs are ignored outside IDLE.
- SRAM bit 11 is always written 0 and ignored on read.
- A null-flagged pointer field is don't-care.

## Timing

Reset values:
- o_cmd_rdy=0, o_rsp_vld=0, o_rsp_ctx=0, o_rsp_ptr=0, o_rsp_err=0.
- o_empty=all-1, o_full=1 (free_cnt=0), o_busy_init=0 in RST_WAIT, 1 in INIT.
- o_prev_ce=0, o_prev_oe=0, o_prev_addr=0, o_prev_din=0.

Cycle counts:
- After arst_n deasserts, INIT spans edges 1..1025. o_cmd_rdy first rises after edge 1025.
- Normal command accepted at edge T: RD during T..T+1, WR during T+1..T+2. o_rsp_vld is registered and high for the cycle after edge T+2. o_cmd_rdy returns the same cycle.
- Throughput is one command per 3 cycles.
- Error command accepted at edge T: o_rsp_vld=1, o_rsp_err=1 for the cycle after T. o_cmd_rdy stays 1.
- o_empty and o_full update with the response.

Reset and pointer rules:
- Reset mid-operation: all state is discarded, any in-flight response is dropped, and re-initialisation runs. A partial SRAM write is irrelevant because INIT rewrites every entry.
- Pointer arithmetic is mod 1024. The last free entry carries null=1.

## Test plan

- Reset release: o_cmd_rdy rises exactly 1025 cycles later. SRAM sees 1024 writes with addr i, din {0, i==1023, (i+1)%1024}. o_full=0.
- Push ctx0 ×3 returns ptr 0,1,2 at 3-cycle spacing. Pop ctx0 ×3 returns 2,1,0. o_empty[0] returns to 1 with the third pop response.
- Pop ctx1 when empty: response at T+1 with err=1, ptr=0. No o_prev_ce pulse.
- Interleave push ctx0 (→0), push ctx1 (→1), pop ctx0 (→0), push ctx2 (→0, free list is LIFO). o_empty = 4'b1001.
- 1024 pushes round-robin across contexts: o_full=1 after the last. The 1025th push returns err=1. Pop ctx3 returns 1023, and the next push returns 1023.
- Assert arst_n in PUSH_WR: all outputs return to reset values. After re-init, push ctx0 returns 0.
